instr_buffer: RTL and testbench
===============================

INSTR_BUFFER -- requirements
Module: instr_buffer

Interface
REQ-001 SHALL have parameter N, default `N (3), the fetch and decode bundle width in instructions.
REQ-002 SHALL have parameter DEPTH, default 8, the buffer capacity in instructions; power of two, at least 2*N.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ib_bundle_valid_i  input  1  fetch presents a bundle this cycle.
REQ-006 ib_lane_valid_i  input  N  per-lane valid mask; contiguous from lane 0.
REQ-007 ib_fetch_i  input  N x FETCH_ENTRY  fetched instructions (pc, inst, prediction metadata), lane 0 oldest.
REQ-008 ib_stall_o  output  1  buffer cannot accept a full bundle; drives fetch's ib_stall_i.
REQ-009 flush_i  input  1  redirect or mispredict; discard all contents.
REQ-010 dec_accept_i  input  $clog2(N+1)  number of head entries decode consumes this cycle (0..N).
REQ-011 dec_valid_o  output  N  dec_valid_o[i] high iff head+i holds a valid entry.
REQ-012 dec_entry_o  output  N x FETCH_ENTRY  oldest N entries, slot 0 = head.
REQ-013 count_dbg_o  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-014 SHALL be a circular FIFO of DEPTH FETCH_ENTRY slots, with head and tail pointers of width $clog2(DEPTH) wrapping modulo DEPTH and a separate occupancy count.
REQ-015 ib_stall_o SHALL be combinational from registered state only: high iff (DEPTH - count) < N.
REQ-016 Enqueue SHALL occur iff ib_bundle_valid_i & !ib_stall_o & !flush_i; enq_n = popcount(ib_lane_valid_i); lanes written at tail, tail+1, ... in lane order.
REQ-017 A bundle offered while ib_stall_o=1 SHALL be ignored with no state change; fetch holds it.
REQ-018 dec_valid_o[i] SHALL equal (i < count); dec_entry_o[i] SHALL equal slot (head+i) mod DEPTH; a new entry is visible to decode no earlier than the cycle after enqueue (1-cycle latency, no bypass).
REQ-019 Dequeue count deq_n SHALL equal min(dec_accept_i, count); dec_accept_i > count SHALL be tolerated and clipped.
REQ-020 Same-cycle enqueue and dequeue SHALL both apply: count_next = count + enq_n - deq_n; head += deq_n; tail += enq_n, all modulo DEPTH for pointers.
REQ-021 flush_i SHALL take priority over enqueue and dequeue: next cycle count=0, head=tail=0, dec_valid_o=0.
REQ-022 count SHALL never exceed DEPTH nor underflow below 0 under any legal input.
REQ-023 Entry contents SHALL be passed through bit-exact; the buffer SHALL NOT reorder or modify fields.
REQ-024 Invalid lanes (ib_lane_valid_i=0) SHALL never occupy slots.

Reset
REQ-025 While reset=1 at a clock edge: count=0, head=tail=0; reset SHALL take priority over flush, enqueue and dequeue.
REQ-026 After reset: dec_valid_o=0, ib_stall_o=0, count_dbg_o=0; slot storage need not be cleared.
REQ-027 Reset asserted mid-operation SHALL discard all contents identically to REQ-025 on the next edge.

Verification
REQ-028 Reset, then one bundle of 3 valid lanes with pc 0x0/0x4/0x8, dec_accept_i=0 -> next cycle count=3, dec_valid_o=3'b111, dec_entry_o[0].pc=0x0, ib_stall_o=0.
REQ-029 Fill to 6 with accept=0 -> ib_stall_o=1 (8-6<3); further bundle ignored, count stays 6; accept=1 -> count=5, stall clears.
REQ-030 Partial bundle mask 3'b011 at count=0 -> count=2, dec_valid_o=3'b011; then accept=3 -> count=0 (clipped to 2).
REQ-031 Wrap: enqueue and dequeue 3 per cycle for 6 cycles -> pc sequence at dec_entry_o[0] strictly 0x0, 0xC, 0x18, ... with no gaps across pointer wrap; count stays 3.
REQ-032 At count=5, flush_i=1 together with a valid bundle and accept=2 -> next cycle count=0, dec_valid_o=0, bundle discarded.
REQ-033 reset=1 with flush_i=0, a valid bundle and count=4 -> next cycle count=0, all outputs at reset values.

Source files
------------

// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and decode: a circular FIFO of fetch entries
// that accepts up to N lanes per cycle and presents the oldest N entries to decode.

package instr_buffer_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_entry_t;
endpackage

module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int N     = 3,
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ib_bundle_valid_i,
    input  logic [N-1:0]                 ib_lane_valid_i,
    input  fetch_entry_t [N-1:0]         ib_fetch_i,
    output logic                         ib_stall_o,
    input  logic                         flush_i,
    input  logic [$clog2(N+1)-1:0]       dec_accept_i,
    output logic [N-1:0]                 dec_valid_o,
    output fetch_entry_t [N-1:0]         dec_entry_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_dbg_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic [CNT_W-1:0]    count_r;

    logic                enq_en_s;
    logic [CNT_W-1:0]    enq_n_s;
    logic [CNT_W-1:0]    deq_n_s;
    logic [CNT_W-1:0]    accept_s;
    logic [CNT_W-1:0]    free_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Stall depends on registered occupancy only, so fetch never sees a loop.
    always_comb begin
        free_s     = CNT_W'(DEPTH) - count_r;
        ib_stall_o = (free_s < CNT_W'(N));
    end

    // Enqueue/dequeue amounts; accept beyond occupancy is clipped.
    always_comb begin
        enq_en_s = ib_bundle_valid_i & ~ib_stall_o & ~flush_i;
        if (enq_en_s) begin
            enq_n_s = popcount(ib_lane_valid_i);
        end else begin
            enq_n_s = {CNT_W{1'b0}};
        end
        accept_s = CNT_W'(dec_accept_i);
        if (accept_s < count_r) begin
            deq_n_s = accept_s;
        end else begin
            deq_n_s = count_r;
        end
    end

    // Pointer and occupancy update; reset outranks flush, flush outranks traffic.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            head_r  <= head_r + PTR_W'(deq_n_s);
            tail_r  <= tail_r + PTR_W'(enq_n_s);
            count_r <= count_r + enq_n_s - deq_n_s;
        end
    end

    // Slot storage: lanes are contiguous from lane 0, so lane i lands at tail+i.
    always_ff @(posedge clock) begin
        if (enq_en_s && !reset) begin
            for (int i = 0; i < N; i++) begin
                if (ib_lane_valid_i[i]) begin
                    mem_r[tail_r + PTR_W'(i)] <= ib_fetch_i[i];
                end
            end
        end
    end

    // Decode window: oldest N entries read straight from storage, no bypass.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            dec_valid_o[i] = (CNT_W'(i) < count_r);
            dec_entry_o[i] = mem_r[head_r + PTR_W'(i)];
        end
        count_dbg_o = count_r;
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.

module tb_instr_buffer;
    import instr_buffer_pkg::*;

    localparam int N     = 3;
    localparam int DEPTH = 8;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 ib_bundle_valid_i;
    logic [N-1:0]         ib_lane_valid_i;
    fetch_entry_t [N-1:0] ib_fetch_i;
    logic                 ib_stall_o;
    logic                 flush_i;
    logic [1:0]           dec_accept_i;
    logic [N-1:0]         dec_valid_o;
    fetch_entry_t [N-1:0] dec_entry_o;
    logic [3:0]           count_dbg_o;

    instr_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .ib_bundle_valid_i (ib_bundle_valid_i),
        .ib_lane_valid_i   (ib_lane_valid_i),
        .ib_fetch_i        (ib_fetch_i),
        .ib_stall_o        (ib_stall_o),
        .flush_i           (flush_i),
        .dec_accept_i      (dec_accept_i),
        .dec_valid_o       (dec_valid_o),
        .dec_entry_o       (dec_entry_o),
        .count_dbg_o       (count_dbg_o)
    );

    always #5 clock = ~clock;

    fetch_entry_t model_q[$];
    int           vectors     = 0;
    int           miscompares = 0;
    logic [31:0]  pc_next     = 32'h0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every meaningful DUT output against the model.
    task automatic compare_all();
        logic [N-1:0] exp_valid;
        exp_valid = '0;
        for (int i = 0; i < N; i++) begin
            exp_valid[i] = (i < model_q.size());
        end
        check("count", 128'(count_dbg_o), 128'(model_q.size()));
        check("stall", 128'(ib_stall_o), 128'((DEPTH - model_q.size()) < N));
        check("dec_valid", 128'(dec_valid_o), 128'(exp_valid));
        for (int i = 0; i < N; i++) begin
            if (i < model_q.size()) begin
                check($sformatf("dec_entry[%0d]", i), 128'(dec_entry_o[i]), 128'(model_q[i]));
            end
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic step(input logic rst, input logic bv, input int nl, input logic fl, input int acc);
        logic enq;
        int   deq;
        enq = !rst && !fl && bv && ((DEPTH - model_q.size()) >= N);
        reset             = rst;
        ib_bundle_valid_i = bv;
        flush_i           = fl;
        dec_accept_i      = acc[1:0];
        for (int i = 0; i < N; i++) begin
            ib_lane_valid_i[i]         = (i < nl);
            ib_fetch_i[i].pc           = (i < nl) ? pc_next + 32'(4 * i) : $urandom;
            ib_fetch_i[i].inst         = $urandom;
            ib_fetch_i[i].pred_taken   = 1'($urandom);
            ib_fetch_i[i].pred_target  = $urandom;
        end
        @(posedge clock);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            deq = (acc < model_q.size()) ? acc : model_q.size();
            repeat (deq) void'(model_q.pop_front());
            if (enq) begin
                for (int i = 0; i < nl; i++) model_q.push_back(ib_fetch_i[i]);
                pc_next = pc_next + 32'(4 * nl);
            end
        end
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        reset = 1'b1; ib_bundle_valid_i = 1'b0; ib_lane_valid_i = '0;
        ib_fetch_i = '0; flush_i = 1'b0; dec_accept_i = 2'd0;
        @(negedge clock);

        step(1'b1, 1'b0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 0, 1'b0, 0);
        check("rst_count", 128'(count_dbg_o), 128'(0));
        check("rst_valid", 128'(dec_valid_o), 128'(0));
        check("rst_stall", 128'(ib_stall_o), 128'(0));

        pc_next = 32'h0;
        step(1'b0, 1'b1, 3, 1'b0, 0);
        check("b1_count", 128'(count_dbg_o), 128'(3));
        check("b1_valid", 128'(dec_valid_o), 128'(3'b111));
        check("b1_pc0", 128'(dec_entry_o[0].pc), 128'(32'h0));
        check("b1_stall", 128'(ib_stall_o), 128'(0));

        step(1'b0, 1'b1, 3, 1'b0, 0);
        check("fill_count", 128'(count_dbg_o), 128'(6));
        check("fill_stall", 128'(ib_stall_o), 128'(1));
        step(1'b0, 1'b1, 3, 1'b0, 0);
        check("ignored_count", 128'(count_dbg_o), 128'(6));
        step(1'b0, 1'b0, 0, 1'b0, 1);
        check("drain1_count", 128'(count_dbg_o), 128'(5));
        check("drain1_stall", 128'(ib_stall_o), 128'(0));

        step(1'b0, 1'b1, 3, 1'b1, 2);
        check("flush_count", 128'(count_dbg_o), 128'(0));
        check("flush_valid", 128'(dec_valid_o), 128'(0));

        step(1'b0, 1'b1, 2, 1'b0, 0);
        check("part_count", 128'(count_dbg_o), 128'(2));
        check("part_valid", 128'(dec_valid_o), 128'(3'b011));
        step(1'b0, 1'b0, 0, 1'b0, 3);
        check("clip_count", 128'(count_dbg_o), 128'(0));

        pc_next = 32'h0;
        step(1'b0, 1'b1, 3, 1'b0, 3);
        check("wrap_pc0", 128'(dec_entry_o[0].pc), 128'(32'h0));
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b1, 3, 1'b0, 3);
            check($sformatf("wrap_pc%0d", k), 128'(dec_entry_o[0].pc), 128'(32'(12 * k)));
            check($sformatf("wrap_cnt%0d", k), 128'(count_dbg_o), 128'(3));
        end

        step(1'b0, 1'b1, 1, 1'b0, 0);
        check("pre_rst_count", 128'(count_dbg_o), 128'(4));
        step(1'b1, 1'b1, 3, 1'b0, 0);
        check("midrst_count", 128'(count_dbg_o), 128'(0));
        check("midrst_valid", 128'(dec_valid_o), 128'(0));
        check("midrst_stall", 128'(ib_stall_o), 128'(0));

        for (int c = 0; c < 3000; c++) begin
            logic rst, fl, bv;
            int   nl, acc;
            rst = ($urandom_range(0, 99) == 0);
            fl  = ($urandom_range(0, 29) == 0);
            bv  = ($urandom_range(0, 9) < 8);
            nl  = $urandom_range(0, N);
            acc = ((c / 200) % 2 == 0) ? $urandom_range(0, 1) : $urandom_range(0, N);
            step(rst, bv, nl, fl, acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
